// File: rtl/intersection_phase_scheduler_if.sv
// Signal bundle between the intersection phase scheduler (slave) and the
// sensors/lamp drivers around it (master).
interface intersection_phase_scheduler_if;
    logic [3:0] sensor;
    logic       ped_req;
    logic       emergency;
    logic [1:0] emer_dir;
    logic [3:0] green;
    logic [3:0] yellow;
    logic       walk;
    logic [1:0] phase;
    logic [1:0] state;

    modport master (
        output sensor, ped_req, emergency, emer_dir,
        input  green, yellow, walk, phase, state
    );

    modport slave (
        input  sensor, ped_req, emergency, emer_dir,
        output green, yellow, walk, phase, state
    );
endinterface

// File: rtl/intersection_phase_scheduler.sv
// Four-approach signal scheduler: round-robin green with gap-out/max-out, yellow and
// all-red clearance, a pedestrian walk phase and emergency preemption.
module intersection_phase_scheduler #(
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 10,
    parameter int YELLOW_T  = 3,
    parameter int ALL_RED_T = 2,
    parameter int WALK_T    = 6,
    parameter int CNT_W     = 5
) (
    input logic                           clk,
    input logic                           rst,
    intersection_phase_scheduler_if.slave bus
);
    localparam logic [1:0] ST_ALL_RED = 2'd0;
    localparam logic [1:0] ST_GREEN   = 2'd1;
    localparam logic [1:0] ST_YELLOW  = 2'd2;
    localparam logic [1:0] ST_WALK    = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_GREEN_LAST = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_GREEN_LAST = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALL_RED_LAST = CNT_W'(ALL_RED_T - 1);
    localparam logic [CNT_W-1:0] WALK_LAST    = CNT_W'(WALK_T - 1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       req_lat_q, req_lat_d;
    logic             ped_lat_q, ped_lat_d;

    logic [3:0] phase_onehot;
    logic       demand_other;
    logic       any_req;
    logic [1:0] rr_next;
    logic [1:0] rr_cand;

    assign phase_onehot = 4'b0001 << phase_q;
    assign demand_other = ped_lat_q | (|(req_lat_q & ~phase_onehot));
    assign any_req      = |req_lat_q;

    // Scan from phase+4 (i.e. phase itself) down to phase+1 so the nearest
    // successor of the last served approach ends up winning.
    always_comb begin
        rr_next = phase_q;
        rr_cand = phase_q;
        for (int k = 4; k >= 1; k--) begin
            rr_cand = phase_q + 2'(k);
            if (req_lat_q[rr_cand]) rr_next = rr_cand;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            ST_ALL_RED: begin
                if (cnt_q >= ALL_RED_LAST) begin
                    if (bus.emergency) begin
                        state_d = ST_GREEN;
                        phase_d = bus.emer_dir;
                    end else if (ped_lat_q) begin
                        state_d = ST_WALK;
                    end else if (any_req) begin
                        state_d = ST_GREEN;
                        phase_d = rr_next;
                    end
                end
            end
            ST_GREEN: begin
                if (bus.emergency) begin
                    if (bus.emer_dir != phase_q) state_d = ST_YELLOW;
                end else if (demand_other &&
                             ((cnt_q >= MIN_GREEN_LAST && !bus.sensor[phase_q]) ||
                              cnt_q >= MAX_GREEN_LAST)) begin
                    state_d = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (cnt_q >= YELLOW_LAST) state_d = ST_ALL_RED;
            end
            default: begin
                if (bus.emergency || cnt_q >= WALK_LAST) state_d = ST_ALL_RED;
            end
        endcase
    end

    always_comb begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (state_d != state_q) cnt_d = '0;
    end

    // Clears are applied after the sets so a coincident request is absorbed by the service.
    always_comb begin
        req_lat_d = req_lat_q | bus.sensor;
        ped_lat_d = ped_lat_q | bus.ped_req;
        if (state_d == ST_GREEN && state_q != ST_GREEN) req_lat_d[phase_d] = 1'b0;
        if (state_d == ST_WALK && state_q != ST_WALK) ped_lat_d = 1'b0;
    end

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_ALL_RED;
            phase_q   <= 2'd3;
            cnt_q     <= '0;
            req_lat_q <= '0;
            ped_lat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            req_lat_q <= req_lat_d;
            ped_lat_q <= ped_lat_d;
        end
    end

    assign bus.green  = (state_q == ST_GREEN)  ? phase_onehot : 4'b0000;
    assign bus.yellow = (state_q == ST_YELLOW) ? phase_onehot : 4'b0000;
    assign bus.walk   = (state_q == ST_WALK);
    assign bus.phase  = phase_q;
    assign bus.state  = state_q;
endmodule
